// File: rtl/dsi_packet_sequencer.sv
// DSI packet sequencer: arbitrates two requesters and streams header, ECC,
// payload and CRC-16 bytes into the packer's d-side port.
module dsi_packet_sequencer #(
  parameter int g_num_req = 2,
  parameter int g_bytes   = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [g_num_req-1:0]     req_i,
  input  logic [25*g_num_req-1:0]  hdr_i,
  output logic [g_num_req-1:0]     gnt_o,
  output logic [g_num_req-1:0]     done_o,
  output logic                     pl_sel_o,
  input  logic [8*g_bytes-1:0]     pl_d_i,
  input  logic [3:0]               pl_size_i,
  input  logic                     pl_valid_i,
  output logic                     pl_rdy_o,
  output logic [8*g_bytes-1:0]     pk_d_o,
  output logic [3:0]               pk_size_o,
  output logic                     pk_valid_o,
  input  logic                     pk_req_i,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_ECC  = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_CRC  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // Parity-bit coverage masks over the 24-bit header {wc_msb, wc_lsb, DI}
  localparam logic [23:0] ECC_M0 = 24'hF12CB7;
  localparam logic [23:0] ECC_M1 = 24'hF2555B;
  localparam logic [23:0] ECC_M2 = 24'h749A6D;
  localparam logic [23:0] ECC_M3 = 24'hB8E38E;
  localparam logic [23:0] ECC_M4 = 24'hDF03F0;
  localparam logic [23:0] ECC_M5 = 24'hEFFC00;

  logic [2:0]  state;
  logic [24:0] hdr;
  logic        last;
  logic        grant_idx;
  logic [15:0] crc;
  logic [15:0] cnt;
  logic [15:0] pl_size_ext;
  logic        overrun;

  function automatic logic [7:0] ecc_calc(input logic [23:0] d);
    return {2'b00, ^(d & ECC_M5), ^(d & ECC_M4), ^(d & ECC_M3),
            ^(d & ECC_M2), ^(d & ECC_M1), ^(d & ECC_M0)};
  endfunction

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  // Earliest byte sits in the most significant valid lane, so walk downwards
  function automatic logic [15:0] crc_word(input logic [15:0] c,
                                           input logic [8*g_bytes-1:0] d,
                                           input logic [3:0] size);
    logic [15:0] r;
    r = c;
    for (int i = g_bytes - 1; i >= 0; i--)
      if (i < int'(size)) r = crc_byte(r, d[8*i +: 8]);
    return r;
  endfunction

  assign grant_idx   = last ? ~req_i[0] : req_i[1];
  assign pl_size_ext = {12'h000, pl_size_i};
  assign overrun     = pl_size_ext > cnt;
  assign busy_o      = (state != S_IDLE);
  assign done_o      = (state == S_DONE) ? gnt_o : '0;

  always_comb begin
    pk_d_o     = '0;
    pk_size_o  = 4'd0;
    pk_valid_o = 1'b0;
    pl_rdy_o   = 1'b0;
    err_o      = 1'b0;
    case (state)
      S_HDR: begin
        pk_d_o     = {hdr[23:16], hdr[7:0], hdr[15:8]};
        pk_size_o  = 4'd3;
        pk_valid_o = pk_req_i;
      end
      S_ECC: begin
        pk_d_o[7:0] = ecc_calc({hdr[15:8], hdr[7:0], hdr[23:16]});
        pk_size_o   = 4'd1;
        pk_valid_o  = pk_req_i;
      end
      S_PAY: begin
        pk_d_o     = pl_d_i;
        pk_size_o  = pl_size_i;
        pk_valid_o = pk_req_i & pl_valid_i;
        pl_rdy_o   = pk_req_i & pl_valid_i;
        err_o      = pk_req_i & pl_valid_i & overrun;
      end
      S_CRC: begin
        pk_d_o[15:0] = {crc[7:0], crc[15:8]};
        pk_size_o    = 4'd2;
        pk_valid_o   = pk_req_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (state == S_IDLE && |req_i)
      hdr <= grant_idx ? hdr_i[25 +: 25] : hdr_i[0 +: 25];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= S_IDLE;
      gnt_o    <= '0;
      pl_sel_o <= 1'b0;
      last     <= 1'b1;
      crc      <= 16'hFFFF;
      cnt      <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          crc <= 16'hFFFF;
          if (|req_i) begin
            gnt_o    <= grant_idx ? 2'b10 : 2'b01;
            pl_sel_o <= grant_idx;
            last     <= grant_idx;
            state    <= S_HDR;
          end
        end
        S_HDR: if (pk_req_i) state <= S_ECC;
        S_ECC: begin
          if (pk_req_i) begin
            if (hdr[24]) begin
              cnt   <= hdr[15:0];
              state <= (hdr[15:0] == 16'h0000) ? S_CRC : S_PAY;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_PAY: begin
          if (pk_valid_o) begin
            crc <= crc_word(crc, pl_d_i, pl_size_i);
            if (overrun) begin
              cnt   <= 16'h0000;
              state <= S_CRC;
            end else begin
              cnt <= cnt - pl_size_ext;
              if (cnt == pl_size_ext) state <= S_CRC;
            end
          end
        end
        S_CRC: if (pk_req_i) state <= S_DONE;
        S_DONE: begin
          gnt_o <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsi_packet_sequencer.sv
// Directed bench for dsi_packet_sequencer: checks byte streams, ECC/CRC,
// latency, arbitration, overrun and mid-packet reset.
module tb_dsi_packet_sequencer;

  typedef logic [7:0] byte_q_t[$];

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [1:0]  req_i;
  logic [49:0] hdr_i;
  logic [1:0]  gnt_o, done_o;
  logic        pl_sel_o;
  logic [23:0] pl_d_i;
  logic [3:0]  pl_size_i;
  logic        pl_valid_i;
  logic        pl_rdy_o;
  logic [23:0] pk_d_o;
  logic [3:0]  pk_size_o;
  logic        pk_valid_o;
  logic        pk_req_i;
  logic        busy_o, err_o;

  dsi_packet_sequencer #(.g_num_req(2), .g_bytes(3)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .hdr_i(hdr_i),
    .gnt_o(gnt_o), .done_o(done_o), .pl_sel_o(pl_sel_o),
    .pl_d_i(pl_d_i), .pl_size_i(pl_size_i), .pl_valid_i(pl_valid_i),
    .pl_rdy_o(pl_rdy_o), .pk_d_o(pk_d_o), .pk_size_o(pk_size_o),
    .pk_valid_o(pk_valid_o), .pk_req_i(pk_req_i), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  byte_q_t    got_q;
  logic [3:0] size_q[$];
  logic [1:0] done_q[$];
  int first_x, last_x, done_cyc, err_cyc, err_n, rdy_n, onehot_bad;
  bit seen_x;
  bit pl_take;

  logic [23:0] pl_words[8];
  logic [3:0]  pl_sizes[8];
  int pl_cnt = 0;
  int pl_idx = 0;
  bit pl_gap = 0;
  bit bp_mode = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_model(input byte_q_t b);
    logic [15:0] c;
    logic [7:0]  v;
    logic        fb;
    c = 16'hFFFF;
    foreach (b[i]) begin
      v = b[i];
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ v[j];
        c  = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  // Monitor: sample mid-cycle, away from the active edge
  always @(negedge clk_i) begin
    pl_take = pl_rdy_o;
    if (pk_valid_o) begin
      for (int i = (pk_size_o > 4'd3) ? 2 : int'(pk_size_o) - 1; i >= 0; i--)
        got_q.push_back(pk_d_o[8*i +: 8]);
      size_q.push_back(pk_size_o);
      if (!seen_x) first_x = cyc;
      seen_x = 1'b1;
      last_x = cyc;
    end
    if (done_o != 2'b00) begin
      done_q.push_back(done_o);
      done_cyc = cyc;
    end
    if (err_o) begin
      err_n++;
      err_cyc = cyc;
    end
    if (pl_rdy_o) rdy_n++;
    if (gnt_o != 2'b00 && !$onehot(gnt_o)) onehot_bad++;
    cyc++;
  end

  // Payload source and packer-ready driver
  always @(posedge clk_i) begin
    #1;
    if (pl_take) pl_idx++;
    pk_req_i = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    if (pl_idx < pl_cnt && (!pl_gap || cyc[0])) begin
      pl_valid_i = 1'b1;
      pl_d_i     = pl_words[pl_idx];
      pl_size_i  = pl_sizes[pl_idx];
    end else begin
      pl_valid_i = 1'b0;
      pl_d_i     = 24'h0;
      pl_size_i  = 4'd0;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic clear_mon();
    got_q.delete();
    size_q.delete();
    done_q.delete();
    seen_x = 1'b0;
    err_n  = 0;
    rdy_n  = 0;
  endtask

  task automatic wait_done(input int n0);
    int k;
    for (k = 0; k < 300; k++) begin
      step();
      if (done_q.size() > n0) break;
    end
    if (k == 300) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic cmp_stream(input string tag, input byte_q_t exp);
    check_eq({tag, "_len"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      check_eq($sformatf("%s_b%0d", tag, i), got_q[i], exp[i]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ctl"}, {gnt_o, done_o, pl_sel_o, pl_rdy_o, pk_valid_o,
                             pk_size_o, busy_o, err_o}, 32'd0);
    check_eq({tag, "_pkd"}, pk_d_o, 32'd0);
  endtask

  initial begin
    byte_q_t exp, pay;
    logic [15:0] c;
    int req_cyc;

    rst_n_i = 1'b1;
    req_i = 2'b00;
    hdr_i = '0;
    pk_req_i = 1'b1;
    pl_valid_i = 1'b0;
    pl_d_i = '0;
    pl_size_i = '0;
    #1 rst_n_i = 1'b0;
    #2;
    check_idle_outputs("reset");
    repeat (3) step();
    rst_n_i = 1'b1;
    step();

    // Short packet, requester 0
    clear_mon();
    hdr_i[24:0] = {1'b0, 2'd0, 6'h05, 16'h0011};
    req_i = 2'b01;
    req_cyc = cyc;
    step();
    check_eq("short_gnt", {gnt_o, busy_o, pl_sel_o}, {2'b01, 1'b1, 1'b0});
    wait_done(0);
    req_i = 2'b00;
    exp = '{8'h05, 8'h11, 8'h00, 8'h36};
    cmp_stream("short", exp);
    check_eq("short_hdr_cyc", first_x - req_cyc, 32'd1);
    check_eq("short_done_cyc", done_cyc - req_cyc, 32'd3);
    check_eq("short_done_idx", done_q[0], 2'b01);
    check_eq("short_err", err_n, 32'd0);
    step();

    // Zero-length long packet, requester 1
    clear_mon();
    hdr_i[49:25] = {1'b1, 2'd0, 6'h39, 16'h0000};
    req_i = 2'b10;
    req_cyc = cyc;
    wait_done(0);
    req_i = 2'b00;
    exp = '{8'h39, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'hFF};
    cmp_stream("zlp", exp);
    check_eq("zlp_crc_cyc", last_x - req_cyc, 32'd3);
    check_eq("zlp_done_cyc", done_cyc - req_cyc, 32'd4);
    check_eq("zlp_rdy", rdy_n, 32'd0);
    check_eq("zlp_done_idx", done_q[0], 2'b10);
    step();

    // Long packet of 7 bytes, gapped payload, then same packet with backpressure
    pl_words[0] = 24'hA1B2C3; pl_sizes[0] = 4'd3;
    pl_words[1] = 24'hD4E5F6; pl_sizes[1] = 4'd3;
    pl_words[2] = 24'h000017; pl_sizes[2] = 4'd1;
    pay = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h17};
    c = crc_model(pay);
    exp = '{8'h29, 8'h07, 8'h00, 8'h39};
    foreach (pay[i]) exp.push_back(pay[i]);
    exp.push_back(c[7:0]);
    exp.push_back(c[15:8]);
    for (int pass = 0; pass < 2; pass++) begin
      clear_mon();
      pl_idx = 0;
      pl_cnt = 3;
      pl_gap = (pass == 0);
      bp_mode = (pass == 1);
      hdr_i[49:25] = {1'b1, 2'd0, 6'h29, 16'd7};
      req_i = 2'b10;
      wait_done(0);
      req_i = 2'b00;
      cmp_stream(pass == 0 ? "long" : "bp", exp);
      check_eq(pass == 0 ? "long_done_cyc" : "bp_done_cyc", done_cyc - last_x, 32'd1);
      check_eq(pass == 0 ? "long_rdy" : "bp_rdy", rdy_n, 32'd3);
      check_eq(pass == 0 ? "long_done_idx" : "bp_done_idx", done_q[0], 2'b10);
      check_eq(pass == 0 ? "long_xfers" : "bp_xfers", size_q.size(), 32'd6);
      step();
    end
    bp_mode = 0;
    pl_gap = 0;

    // Overrun: wc = 2 with a size-3 word
    clear_mon();
    pl_words[0] = 24'h112233; pl_sizes[0] = 4'd3;
    pl_idx = 0;
    pl_cnt = 1;
    hdr_i[24:0] = {1'b1, 2'd0, 6'h29, 16'd2};
    req_i = 2'b01;
    wait_done(0);
    req_i = 2'b00;
    check_eq("ovr_err_n", err_n, 32'd1);
    check_eq("ovr_len", got_q.size(), 32'd9);
    if (got_q.size() == 9)
      check_eq("ovr_fwd", {got_q[4], got_q[5], got_q[6]}, 24'h112233);
    check_eq("ovr_crc_next", last_x - err_cyc, 32'd1);
    if (size_q.size() == 4)
      check_eq("ovr_crc_size", size_q[3], 4'd2);
    else
      check_eq("ovr_xfers", size_q.size(), 32'd4);
    check_eq("ovr_done_idx", done_q[0], 2'b01);
    step();

    // Reset during PAY, then a clean short packet from requester 0
    clear_mon();
    pl_cnt = 0;
    pl_idx = 0;
    hdr_i[49:25] = {1'b1, 2'd0, 6'h29, 16'd7};
    req_i = 2'b10;
    repeat (3) step();
    check_eq("rst_in_pay", {busy_o, 4'(got_q.size())}, {1'b1, 4'd4});
    rst_n_i = 1'b0;
    req_i = 2'b00;
    #1;
    check_idle_outputs("rst_mid");
    repeat (2) step();
    rst_n_i = 1'b1;
    step();
    check_eq("rst_no_done", done_q.size(), 32'd0);
    clear_mon();
    hdr_i[24:0] = {1'b0, 2'd0, 6'h05, 16'h0011};
    req_i = 2'b01;
    req_cyc = cyc;
    wait_done(0);
    req_i = 2'b00;
    exp = '{8'h05, 8'h11, 8'h00, 8'h36};
    cmp_stream("post_rst", exp);
    check_eq("post_rst_hdr_cyc", first_x - req_cyc, 32'd1);
    check_eq("post_rst_idx", done_q[0], 2'b01);
    step();

    // Arbitration: both requests held
    clear_mon();
    onehot_bad = 0;
    hdr_i[24:0]  = {1'b0, 2'd0, 6'h05, 16'h0011};
    hdr_i[49:25] = {1'b0, 2'd1, 6'h15, 16'h00AA};
    req_i = 2'b11;
    for (int n = 0; n < 4; n++) wait_done(n);
    req_i = 2'b00;
    check_eq("arb_count", done_q.size(), 32'd4);
    if (done_q.size() == 4)
      check_eq("arb_order", {done_q[0], done_q[1], done_q[2], done_q[3]}, 8'b10_01_10_01);
    check_eq("arb_onehot", onehot_bad, 32'd0);
    repeat (3) step();
    check_eq("arb_idle", {busy_o, gnt_o}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dsi_packet_sequencer.md
# dsi_packet_sequencer

Packet-level controller in front of `dsi_packer`. It arbitrates between two packet requesters and builds each DSI packet as a byte stream into the packer's input port:
- a 4-byte header (DI, WC LSB, WC MSB, ECC);
- for long packets, the payload pulled from the granted requester;
- for long packets, a 2-byte CRC-16.

It owns the packer's `d_*` side. It never drives the packer's `q_*` side.

## Interface
Parameters:
- `g_num_req`, 2, number of requesters. Fixed at 2; arrays below are indexed by requester.
- `g_bytes`, 3, byte width of the payload and packer data ports.

Ports:
- `clk_i` in 1: single clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `req_i` in 2: packet request per requester. Level signal, held until `done_o`.
- `hdr_i` in 50: per requester `{long[24], vc[23:22], dt[21:16], wc[15:0]}`, requester n at bits `[25n+24:25n]`. Must be stable while `req_i` is high. For short packets, `wc` carries data0 in `[7:0]` and data1 in `[15:8]`.
- `gnt_o` out 2: one-hot, high from grant until `done_o`.
- `done_o` out 2: one-cycle pulse when the last packet byte has been accepted by the packer.
- `pl_sel_o` out 1: index of the requester whose payload is being drawn.
- `pl_d_i` in 24: payload bytes. The earliest byte sits in the most significant valid byte.
- `pl_size_i` in 4: payload byte count, 1..3.
- `pl_valid_i` in 1: payload word available.
- `pl_rdy_o` out 1: payload word consumed this cycle.
- `pk_d_o` out 24: bytes to the packer, same byte ordering as `pl_d_i`.
- `pk_size_o` out 4: byte count 1..3.
- `pk_valid_o` out 1: transfer into the packer this cycle.
- `pk_req_i` in 1: packer can accept `g_bytes` bytes this cycle.
- `busy_o` out 1: state not IDLE.
- `err_o` out 1: one-cycle pulse on a payload overrun.

## Operation
- **States:** IDLE, HDR, ECC, PAY, CRC, DONE.
- **IDLE:**
  - If any `req_i` bit is high, grant round-robin starting after the last granted index. After reset the last-granted index is 1, so requester 0 wins first.
  - Latch the granted `hdr_i` into an internal header register.
  - Set `gnt_o`, `pl_sel_o`, and `busy_o`.
  - Go to HDR.
- **HDR:**
  - Drive `pk_d_o = {DI, wc[7:0], wc[15:8]}` with `DI = {vc, dt}` and `pk_size_o = 3`.
  - On transfer, go to ECC.
- **ECC:**
  - Drive the byte in `pk_d_o[7:0]` with `pk_size_o = 1`.
  - ECC is the DSI Hamming ECC over the 24-bit header `{wc[15:8], wc[7:0], DI}`: P0..P5 in bits 5:0, bits 7:6 zero.
  - On transfer: if long, go to PAY, or to CRC directly when `wc == 0`; otherwise go to DONE.
- **PAY:**
  - `pk_d_o`, `pk_size_o` = `pl_d_i`, `pl_size_i`.
  - `pk_valid_o = pl_rdy_o = pk_req_i & pl_valid_i`.
  - A 16-bit remaining-byte counter is loaded with `wc` and decremented by `pl_size_i` per transfer.
  - CRC is updated byte-serially across all valid bytes of the word, earliest byte first.
  - When the counter reaches 0, go to CRC.
  - If `pl_size_i` exceeds the remaining count: forward the word unchanged, set the counter to 0, pulse `err_o`, then go to CRC.
- **CRC:**
  - Drive `pk_d_o[15:0] = {crc[7:0], crc[15:8]}`, `pk_size_o = 2`, so the low byte goes first.
  - CRC is CRC-16/CCITT reflected (poly 0x8408), init 0xFFFF, no final XOR, and is re-initialised in IDLE.
  - On transfer, go to DONE.
- **DONE:**
  - Pulse `done_o` for the granted index.
  - Clear `gnt_o` and `busy_o` at the end of the cycle; go to IDLE.
  - A new grant is possible at the earliest in the following IDLE cycle.

## Timing
- **Reset values:** state IDLE; `gnt_o = 0`, `done_o = 0`, `pl_sel_o = 0`, `pl_rdy_o = 0`, `pk_valid_o = 0`, `pk_d_o = 0`, `pk_size_o = 0`, `busy_o = 0`, `err_o = 0`; CRC 0xFFFF; counter 0.
- **Reset mid-packet:** aborts immediately; no `done_o` is issued.
- **Packer handshake:**
  - In HDR, ECC and CRC, `pk_valid_o = pk_req_i`. This is a combinational path from `pk_req_i`.
  - `pk_d_o` and `pk_size_o` are valid whenever `pk_valid_o` is high.
  - A transfer occurs on every cycle `pk_valid_o` is high; no bytes are dropped or repeated.
- **Latency with `pk_req_i` constantly high:**
  - Request seen in IDLE at cycle 0.
  - HDR transfers at cycle 1, ECC at cycle 2.
  - A short packet gives `done_o` at cycle 3.
  - A long packet of N words gives CRC at cycle 3+N and `done_o` at cycle 4+N.
- **Stalls:** `pk_req_i` low holds the state and all latched values. `pl_valid_i` low in PAY inserts bubbles, with `pk_valid_o` low.
- **Request timing:** a request dropped before `done_o` does not abort the packet. Requests arriving during a packet wait for IDLE.

## Test plan
- **Short packet with ECC:** requester 0, `hdr = {0, 0, 0x05, 0x0011}`, `pk_req_i = 1` → packer bytes 05 11 00 36; `done_o[0]` at cycle 3; `err_o` never pulses.
- **Zero-length long packet:** requester 1, long, dt 0x39, `wc = 0` → bytes 39 00 00 ECC FF FF; no `pl_rdy_o` pulses.
- **Long packet of 7 bytes:** payload sizes 3, 3, 1 with `pl_valid_i` gapped → exactly 7 payload bytes in order; CRC bytes match a software CRC-16/0x8408 model; `done_o[1]` one cycle after the CRC transfer.
- **Packer backpressure:** `pk_req_i` random at 50% → byte stream identical to the no-stall run; state held on every low cycle.
- **Arbitration:** both requests held continuously → grants alternate 0, 1, 0, 1; `gnt_o` is always one-hot.
- **Overrun and reset:** with `wc = 2`, supply a size-3 word → `err_o` pulse, then CRC. Separately, assert `rst_n_i` during PAY → all outputs at reset values immediately; next request starts cleanly with HDR.
